draw_donkey: RTL and testbench

Renders the Donkey sprite onto the VGA pixel stream at the position produced by the intro animation stage, directly downstream of it. It consumes `xpos`, `ypos` and `animation`, and forms sprite-ROM addresses. While the intro animation runs, it alternates two sprite frames. The output is a pipeline-delayed copy of the incoming VGA timing bus with the sprite composited over the background.

---
 rtl/draw_donkey.sv | 162 ++++++++++++++++
 tb/tb_draw_donkey.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_donkey.sv
// draw_donkey: overlays the Donkey sprite on the VGA pixel stream at (xpos, ypos).
// The sprite ROM is external and synchronous, with one cycle of read latency.
// While animation is high, the sprite frame bit toggles every FRAME_TICKS vsync rises.
//
// Ports:
//   clk, rst                       pixel clock, async active-high reset
//   animation                      intro animation active (enables frame alternation)
//   xpos, ypos                     sprite top-left corner in screen pixels
//   hcount_in .. rgb_in            incoming VGA timing bus and background pixel
//   rom_data                       sprite ROM output for pixel_addr (1-cycle latency)
//   pixel_addr                     {frame, row, col} sprite ROM address, 0 outside the box
//   hcount_out .. vblnk_out        timing bus delayed by 3 clocks
//   rgb_out                        composited pixel, aligned with the timing outputs
module draw_donkey #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned FRAME_TICKS = 8,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  animation,
    input  logic [11:0]                           xpos,
    input  logic [11:0]                           ypos,
    input  logic [10:0]                           hcount_in,
    input  logic [10:0]                           vcount_in,
    input  logic                                  hsync_in,
    input  logic                                  vsync_in,
    input  logic                                  hblnk_in,
    input  logic                                  vblnk_in,
    input  logic [11:0]                           rgb_in,
    input  logic [11:0]                           rom_data,
    output logic [$clog2(WIDTH)+$clog2(HEIGHT):0] pixel_addr,
    output logic [10:0]                           hcount_out,
    output logic [10:0]                           vcount_out,
    output logic                                  hsync_out,
    output logic                                  vsync_out,
    output logic                                  hblnk_out,
    output logic                                  vblnk_out,
    output logic [11:0]                           rgb_out
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);
    localparam int unsigned TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_TICKS - 1);

    localparam logic [0:0] ST_STILL = 1'b0;
    localparam logic [0:0] ST_ANIM  = 1'b1;

    // Timing bus packed as {hcount, vcount, hsync, vsync, hblnk, vblnk}.
    logic [25:0]   w_tim_in;
    logic [25:0]   r1_tim, r2_tim;
    logic          r1_in_box, r2_in_box;
    logic [11:0]   r1_rgb, r2_rgb;

    logic [12:0]   w_h, w_v, w_x, w_y;
    logic          w_in_box;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [11:0]   w_rgb_d;

    logic [0:0]    r_state, w_state_d;
    logic          r_frame, w_frame_d;
    logic [TW-1:0] r_tick, w_tick_d;
    logic          r_vsync_prev;
    logic          w_vs_rise;

    assign w_tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    // 13-bit compares so xpos+WIDTH cannot wrap back to the left edge.
    assign w_h = {2'b00, hcount_in};
    assign w_v = {2'b00, vcount_in};
    assign w_x = {1'b0, xpos};
    assign w_y = {1'b0, ypos};
    assign w_in_box = (w_h >= w_x) && (w_h < w_x + 13'(WIDTH)) &&
                      (w_v >= w_y) && (w_v < w_y + 13'(HEIGHT));

    // Low bits of the difference only depend on the low bits of the operands.
    assign w_col = hcount_in[CW-1:0] - xpos[CW-1:0];
    assign w_row = vcount_in[RW-1:0] - ypos[RW-1:0];

    assign w_vs_rise = vsync_in & ~r_vsync_prev;

    // Frame FSM: frame only moves on a vsync rise or when animation drops.
    always_comb begin
        w_state_d = r_state;
        w_frame_d = r_frame;
        w_tick_d  = r_tick;
        case (r_state)
            ST_STILL: begin
                w_frame_d = 1'b0;
                w_tick_d  = '0;
                // A vsync rise on the entry edge is deliberately not counted.
                if (animation) w_state_d = ST_ANIM;
            end
            ST_ANIM: begin
                if (!animation) begin
                    w_state_d = ST_STILL;
                    w_frame_d = 1'b0;
                    w_tick_d  = '0;
                end else if (w_vs_rise) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_d  = '0;
                        w_frame_d = ~r_frame;
                    end else begin
                        w_tick_d = r_tick + 1'b1;
                    end
                end
            end
            default: w_state_d = ST_STILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_STILL;
            r_frame      <= 1'b0;
            r_tick       <= '0;
            r_vsync_prev <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_frame      <= w_frame_d;
            r_tick       <= w_tick_d;
            r_vsync_prev <= vsync_in;
        end
    end

    // Blanking wins, then opaque sprite pixels, then the background.
    always_comb begin
        w_rgb_d = r2_rgb;
        if (r2_tim[1] || r2_tim[0]) begin
            w_rgb_d = 12'h000;
        end else if (r2_in_box && (rom_data != TRANSPARENT)) begin
            w_rgb_d = rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            r1_in_box  <= 1'b0;
            r1_rgb     <= 12'h000;
            r1_tim     <= '0;
            r2_in_box  <= 1'b0;
            r2_rgb     <= 12'h000;
            r2_tim     <= '0;
            rgb_out    <= 12'h000;
            {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= '0;
        end else begin
            pixel_addr <= w_in_box ? {r_frame, w_row, w_col} : '0;
            r1_in_box  <= w_in_box;
            r1_rgb     <= rgb_in;
            r1_tim     <= w_tim_in;
            // The ROM registers pixel_addr on this edge; match its latency.
            r2_in_box  <= r1_in_box;
            r2_rgb     <= r1_rgb;
            r2_tim     <= r1_tim;
            rgb_out    <= w_rgb_d;
            {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} <= r2_tim;
        end
    end
endmodule

// File: tb/tb_draw_donkey.sv
// tb_draw_donkey: scoreboard bench for draw_donkey with default parameters.
// Stimulus pushes expected outputs (due 3 clocks later) and expected ROM addresses
// (due 1 clock later); a negedge monitor pops and compares them.
module tb_draw_donkey;
    localparam int SW = 64;
    localparam int SH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        animation = 1'b0;
    logic [11:0] xpos = 12'd0, ypos = 12'd0;
    logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = 12'h000;
    logic [11:0] rom_data = 12'h000;
    logic [12:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_donkey dut (
        .clk        (clk),
        .rst        (rst),
        .animation  (animation),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rom_data   (rom_data),
        .pixel_addr (pixel_addr),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: F00 everywhere; in tmode column 0 holds the transparent key.
    logic tmode = 1'b0;
    always @(posedge clk) rom_data <= (tmode && pixel_addr[5:0] == 6'd0) ? 12'h000 : 12'hF00;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [10:0] hc, vc;
        logic        hs, vs, hb, vb;
    } exp_t;
    typedef struct {
        int          due;
        logic [12:0] addr;
    } aexp_t;

    exp_t  q[$];
    aexp_t aq[$];
    int    total = 0;
    int    bad = 0;
    int    sx = 484, sy = 672;
    logic  exp_frame = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        exp_t  e;
        aexp_t a;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due != cyc) chk("sched", cyc, e.due);
            else begin
                chk("rgb_out", rgb_out, e.rgb);
                chk("hcount_out", hcount_out, e.hc);
                chk("vcount_out", vcount_out, e.vc);
                chk("hsync_out", hsync_out, e.hs);
                chk("vsync_out", vsync_out, e.vs);
                chk("hblnk_out", hblnk_out, e.hb);
                chk("vblnk_out", vblnk_out, e.vb);
            end
        end
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            a = aq.pop_front();
            if (a.due != cyc) chk("asched", cyc, a.due);
            else chk("pixel_addr", pixel_addr, a.addr);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rgb"}, rgb_out, 0);
        chk({tag, "_hc"}, hcount_out, 0);
        chk({tag, "_vc"}, vcount_out, 0);
        chk({tag, "_sync"}, {hsync_out, vsync_out}, 0);
        chk({tag, "_blnk"}, {hblnk_out, vblnk_out}, 0);
        chk({tag, "_addr"}, pixel_addr, 0);
    endtask

    // Drive one pixel after the next rising edge and queue its expectations.
    task automatic issue(input int h, input int v, input logic hb, input logic vb,
                         input logic vs, input logic an, input logic rel = 1'b0);
        exp_t        e;
        aexp_t       a;
        logic        inb;
        int          col, row;
        logic [11:0] bg;
        @(posedge clk);
        #1;
        if (rel) begin
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                e = '{cyc + k, 12'h0, 11'h0, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0};
                q.push_back(e);
            end
            a = '{cyc, 13'h0};
            aq.push_back(a);
        end
        xpos = 12'(sx);
        ypos = 12'(sy);
        animation = an;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in = (h % 3) == 0;
        vsync_in = vs;
        hblnk_in = hb;
        vblnk_in = vb;
        bg = {4'(h), 4'(v), 4'h5};
        rgb_in = bg;
        inb = (h >= sx) && (h < sx + SW) && (v >= sy) && (v < sy + SH);
        col = h - sx;
        row = v - sy;
        e.due = cyc + 3;
        e.hc = 11'(h);
        e.vc = 11'(v);
        e.hs = (h % 3) == 0;
        e.vs = vs;
        e.hb = hb;
        e.vb = vb;
        e.rgb = (hb || vb) ? 12'h000 : (inb && !(tmode && col == 0)) ? 12'hF00 : bg;
        q.push_back(e);
        a.due = cyc + 1;
        a.addr = inb ? {exp_frame, 6'(row), 6'(col)} : 13'h0;
        aq.push_back(a);
    endtask

    task automatic pulse(input logic an);
        issue(0, 0, 1'b1, 1'b1, 1'b1, an);
        issue(0, 0, 1'b1, 1'b1, 1'b1, an);
        issue(0, 0, 1'b1, 1'b1, 1'b0, an);
    endtask

    task automatic box_probe(input logic an);
        issue(489, 675, 1'b0, 1'b0, 1'b0, an);
        issue(540, 730, 1'b0, 1'b0, 1'b0, an);
    endtask

    int hl[7] = '{0, 483, 484, 485, 547, 548, 1023};
    int vl[5] = '{671, 672, 700, 735, 736};
    int xl[7] = '{990, 999, 1000, 1001, 1023, 0, 39};
    int k;

    initial begin
        #1 rst = 1'b1;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clk);
        #3 check_zero("reset_held");
        issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Box edges with an all-opaque sprite.
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 7; i++)
                issue(hl[i], vl[j], 1'b0, 1'b0, 1'(i % 2), 1'b0);
        issue(500, 700, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(500, 700, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1100, 700, 1'b1, 1'b0, 1'b0, 1'b0);

        // Transparent column 0.
        repeat (3) issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        tmode = 1'b1;
        for (int h = 483; h <= 486; h++) issue(h, 680, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        tmode = 1'b0;

        // Right-edge clipping.
        sx = 1000;
        for (int i = 0; i < 7; i++) issue(xl[i], 700, 1'b0, 1'b0, 1'b0, 1'b0);
        sx = 484;

        // Frame alternation: toggle every 8 counted vsync rises.
        issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        k = 0;
        exp_frame = 1'b0;
        box_probe(1'b1);
        for (int p = 1; p <= 55; p++) begin
            pulse(1'b1);
            k++;
            exp_frame = 1'((k / 8) % 2);
            box_probe(1'b1);
        end
        // tick=7, frame=0: dropping animation on a vsync rise must not toggle.
        issue(0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        k = 0;
        exp_frame = 1'b0;
        box_probe(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        box_probe(1'b0);
        // Animation rises with vsync: that rise is not counted.
        pulse(1'b1);
        box_probe(1'b1);
        for (int p = 1; p <= 8; p++) begin
            pulse(1'b1);
            k++;
            exp_frame = 1'((k / 8) % 2);
            box_probe(1'b1);
        end
        issue(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_frame = 1'b0;
        box_probe(1'b0);

        // Mid-line reset for two clock edges.
        issue(489, 675, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(600, 675, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_zero("reset_midline");
        q.delete();
        aq.delete();
        @(posedge clk);
        issue(490, 676, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(600, 676, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(484, 672, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(547, 735, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("drain_q", q.size(), 0);
        chk("drain_aq", aq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
